// File: rtl/boss_missile_control.sv
// boss_missile_control: boss-fired missile pool with frame-rate motion, player hit/lives tracking and a per-pixel flag.
// Optional feature macro BOSS_MISSILE_AIM_EN adds a per-missile horizontal drift toward the player.
module boss_missile_control #(
  parameter int NUM_MISSILES  = 3,
  parameter int MISSILE_SPEED = 4,
  parameter int FIRE_PERIOD   = 60,
  parameter int SPAWN_OFFSET  = 24,
  parameter int HIT_THRESHOLD = 16,
  parameter int PLAYER_LIVES  = 3,
  parameter int INVULN_FRAMES = 30,
  parameter int SCREEN_BOTTOM = 479
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    enable,
  input  logic [9:0]              boss_x_pos,
  input  logic [9:0]              boss_y_pos,
  input  logic [9:0]              player_x_pos,
  input  logic [9:0]              player_y_pos,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic                    is_boss_missile,
  output logic [NUM_MISSILES-1:0] missile_active,
  output logic                    is_player_hit,
  output logic [2:0]              lives,
  output logic                    is_player_dead
);

  localparam int FC_W = $clog2(FIRE_PERIOD + 1) + 1;
  localparam int IV_W = $clog2(INVULN_FRAMES + 1) + 1;

  logic                    frame_clk_q;
  logic                    tick;
  logic [NUM_MISSILES-1:0] act;
  logic [NUM_MISSILES-1:0] act_n;
  logic [9:0]              mx   [NUM_MISSILES];
  logic [9:0]              mx_n [NUM_MISSILES];
  logic [9:0]              my   [NUM_MISSILES];
  logic [9:0]              my_n [NUM_MISSILES];
  logic [FC_W-1:0]         fire_cnt;
  logic [FC_W-1:0]         fire_n;
  logic [FC_W-1:0]         fire_dec;
  logic [IV_W-1:0]         inv_cnt;
  logic [IV_W-1:0]         inv_n;
  logic [2:0]              lives_n;
  logic                    dead_n;
  logic                    hit_n;
  logic                    hit_any;
  logic                    spawned;
`ifdef BOSS_MISSILE_AIM_EN
  logic signed [2:0]       dx   [NUM_MISSILES];
  logic signed [2:0]       dx_n [NUM_MISSILES];
  logic signed [11:0]      nx;
`endif

  // Magnitude of a - b, taken as an 11-bit signed difference.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? -d : d;
  endfunction

`ifdef BOSS_MISSILE_AIM_EN
  function automatic logic signed [2:0] aim_dx(input logic [9:0] px, input logic [9:0] bx);
    if (abs_diff(px, bx) < 11'(HIT_THRESHOLD)) return 3'sd0;
    return (px < bx) ? -3'sd2 : 3'sd2;
  endfunction
`endif

  assign tick           = frame_clk & ~frame_clk_q;
  assign missile_active = act;

  always_comb begin
    act_n    = act;
    mx_n     = mx;
    my_n     = my;
    lives_n  = lives;
    inv_n    = inv_cnt;
    fire_n   = fire_cnt;
    hit_any  = 1'b0;
    spawned  = 1'b0;
    fire_dec = (fire_cnt == '0) ? '0 : fire_cnt - 1'b1;
`ifdef BOSS_MISSILE_AIM_EN
    dx_n     = dx;
    nx       = '0;
`endif
    if (tick) begin
      // Hit and move both look at pre-tick positions; a dead player just flushes the pool.
      if (is_player_dead) begin
        act_n = '0;
      end else begin
        for (int i = 0; i < NUM_MISSILES; i++) begin
          if (act[i]) begin
            if (inv_cnt == '0 &&
                abs_diff(mx[i], player_x_pos) < 11'(HIT_THRESHOLD) &&
                abs_diff(my[i], player_y_pos) < 11'(HIT_THRESHOLD)) begin
              act_n[i] = 1'b0;
              hit_any  = 1'b1;
            end else if ({1'b0, my[i]} + 11'(MISSILE_SPEED) > 11'(SCREEN_BOTTOM)) begin
              act_n[i] = 1'b0;
            end else begin
              my_n[i] = my[i] + 10'(MISSILE_SPEED);
`ifdef BOSS_MISSILE_AIM_EN
              nx = $signed({2'b00, mx[i]}) + $signed({{9{dx[i][2]}}, dx[i]});
              if (nx < 12'sd0 || nx > 12'sd639) act_n[i] = 1'b0;
              else mx_n[i] = nx[9:0];
`endif
            end
          end
        end
      end

      if (hit_any) begin
        lives_n = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
        inv_n   = IV_W'(INVULN_FRAMES);
      end else if (inv_cnt != '0) begin
        inv_n = inv_cnt - 1'b1;
      end

      // Slots freed above are already visible in act_n, so they can be reused this tick.
      fire_n = fire_dec;
      if (fire_dec == '0 && enable && !is_player_dead) begin
        for (int i = 0; i < NUM_MISSILES; i++) begin
          if (!spawned && !act_n[i]) begin
            act_n[i] = 1'b1;
            mx_n[i]  = boss_x_pos;
            my_n[i]  = boss_y_pos + 10'(SPAWN_OFFSET);
`ifdef BOSS_MISSILE_AIM_EN
            dx_n[i]  = aim_dx(player_x_pos, boss_x_pos);
`endif
            spawned  = 1'b1;
          end
        end
        if (spawned) fire_n = FC_W'(FIRE_PERIOD);
      end
    end
    dead_n = is_player_dead | (lives_n == 3'd0);
    hit_n  = hit_any;
  end

  always_ff @(posedge Clk) begin
    frame_clk_q <= frame_clk;
    if (!Reset) begin
      act            <= '0;
      mx             <= '{default: '0};
      my             <= '{default: '0};
`ifdef BOSS_MISSILE_AIM_EN
      dx             <= '{default: '0};
`endif
      lives          <= 3'(PLAYER_LIVES);
      fire_cnt       <= FC_W'(FIRE_PERIOD);
      inv_cnt        <= '0;
      is_player_hit  <= 1'b0;
      is_player_dead <= 1'b0;
    end else begin
      act            <= act_n;
      mx             <= mx_n;
      my             <= my_n;
`ifdef BOSS_MISSILE_AIM_EN
      dx             <= dx_n;
`endif
      lives          <= lives_n;
      fire_cnt       <= fire_n;
      inv_cnt        <= inv_n;
      is_player_hit  <= hit_n;
      is_player_dead <= dead_n;
    end
  end

  always_comb begin
    is_boss_missile = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (act[i] && abs_diff(DrawX, mx[i]) <= 11'd2 && abs_diff(DrawY, my[i]) <= 11'd4)
        is_boss_missile = 1'b1;
    end
  end

endmodule

// File: tb/tb_boss_missile_control.sv
// tb_boss_missile_control: directed and randomized checks of boss_missile_control against a frame-level model.
module tb_boss_missile_control;

  localparam int N     = 3;
  localparam int SPEED = 4;
  localparam int FP    = 60;
  localparam int OFS   = 24;
  localparam int THR   = 16;
  localparam int LIV0  = 3;
  localparam int INV   = 30;
  localparam int BOT   = 479;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         frame_clk = 1'b0;
  logic         enable = 1'b0;
  logic [9:0]   boss_x_pos = '0;
  logic [9:0]   boss_y_pos = '0;
  logic [9:0]   player_x_pos = '0;
  logic [9:0]   player_y_pos = '0;
  logic [9:0]   DrawX = '0;
  logic [9:0]   DrawY = '0;
  logic         is_boss_missile;
  logic [N-1:0] missile_active;
  logic         is_player_hit;
  logic [2:0]   lives;
  logic         is_player_dead;

  int n_pass = 0;
  int n_total = 0;

  // Frame-level reference model
  bit m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_dx  [N];
  int m_lives, m_fire, m_inv;
  bit m_dead, m_hit;

  always #5 Clk = ~Clk;

  boss_missile_control #(
    .NUM_MISSILES(N), .MISSILE_SPEED(SPEED), .FIRE_PERIOD(FP), .SPAWN_OFFSET(OFS),
    .HIT_THRESHOLD(THR), .PLAYER_LIVES(LIV0), .INVULN_FRAMES(INV), .SCREEN_BOTTOM(BOT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .boss_x_pos(boss_x_pos), .boss_y_pos(boss_y_pos),
    .player_x_pos(player_x_pos), .player_y_pos(player_y_pos),
    .DrawX(DrawX), .DrawY(DrawY),
    .is_boss_missile(is_boss_missile), .missile_active(missile_active),
    .is_player_hit(is_player_hit), .lives(lives), .is_player_dead(is_player_dead)
  );

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [N-1:0] m_act_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic bit m_draw(int px, int py);
    for (int i = 0; i < N; i++)
      if (m_act[i] && iabs(px - m_x[i]) <= 2 && iabs(py - m_y[i]) <= 4) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0;
    end
    m_lives = LIV0; m_fire = FP; m_inv = 0; m_dead = 0; m_hit = 0;
  endtask

  task automatic model_step();
    bit was_dead;
    bit any;
    int free_i;
    int px, py, bx, by;
    was_dead = m_dead; any = 0; free_i = -1;
    px = int'(player_x_pos); py = int'(player_y_pos);
    bx = int'(boss_x_pos);   by = int'(boss_y_pos);
    for (int i = 0; i < N; i++) begin
      if (was_dead) m_act[i] = 0;
      else if (m_act[i]) begin
        if (m_inv == 0 && iabs(m_x[i] - px) < THR && iabs(m_y[i] - py) < THR) begin
          m_act[i] = 0; any = 1;
        end else if (m_y[i] + SPEED > BOT) begin
          m_act[i] = 0;
        end else if (m_x[i] + m_dx[i] < 0 || m_x[i] + m_dx[i] > 639) begin
          m_act[i] = 0;
        end else begin
          m_y[i] += SPEED; m_x[i] += m_dx[i];
        end
      end
    end
    if (any) begin
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      m_inv = INV;
    end else if (m_inv > 0) m_inv--;
    if (m_lives == 0) m_dead = 1;
    m_hit = any;
    if (m_fire > 0) m_fire--;
    if (m_fire == 0 && enable && !was_dead) begin
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) free_i = i;
      if (free_i >= 0) begin
        m_act[free_i] = 1; m_x[free_i] = bx; m_y[free_i] = (by + OFS) % 1024;
        m_dx[free_i] = 0;
`ifdef BOSS_MISSILE_AIM_EN
        if (iabs(px - bx) >= THR) m_dx[free_i] = (px < bx) ? -2 : 2;
`endif
        m_fire = FP;
      end
    end
  endtask

  task automatic tick();
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b0; frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    enable = 1'b0;
    do_reset();
    n_total++; if (lives !== 3'd3) $display("FAIL reset_lives got=%0d exp=3", lives); else n_pass++;
    n_total++; if (missile_active !== '0) $display("FAIL reset_active got=%b exp=000", missile_active); else n_pass++;
    n_total++; if (is_player_dead !== 1'b0) $display("FAIL reset_dead got=%b exp=0", is_player_dead); else n_pass++;
    n_total++; if (is_player_hit !== 1'b0) $display("FAIL reset_hit got=%b exp=0", is_player_hit); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479)); #1;
      n_total++;
      if (is_boss_missile !== 1'b0) $display("FAIL reset_draw (%0d,%0d) got=%b exp=0", DrawX, DrawY, is_boss_missile);
      else n_pass++;
    end
  endtask

  task automatic test_spawn();
    logic [N-1:0] exp_act;
    player_x_pos = 10'd0; player_y_pos = 10'd0;
    do_reset();
    enable = 1'b1; boss_x_pos = 10'd320; boss_y_pos = 10'd100;
    for (int t = 1; t <= 60; t++) begin
      tick();
      exp_act = (t == 60) ? 3'b001 : 3'b000;
      n_total++;
      if (missile_active !== exp_act) $display("FAIL spawn_act t=%0d got=%b exp=%b", t, missile_active, exp_act);
      else n_pass++;
    end
    DrawX = 10'd320; DrawY = 10'd124; #1;
    n_total++; if (is_boss_missile !== 1'b1) $display("FAIL spawn_draw_centre got=%b exp=1", is_boss_missile); else n_pass++;
    DrawX = 10'd323; #1;
    n_total++; if (is_boss_missile !== 1'b0) $display("FAIL spawn_draw_x3 got=%b exp=0", is_boss_missile); else n_pass++;
    DrawX = 10'd322; DrawY = 10'd128; #1;
    n_total++; if (is_boss_missile !== 1'b1) $display("FAIL spawn_draw_corner got=%b exp=1", is_boss_missile); else n_pass++;
    DrawX = 10'd320; DrawY = 10'd129; #1;
    n_total++; if (is_boss_missile !== 1'b0) $display("FAIL spawn_draw_y5 got=%b exp=0", is_boss_missile); else n_pass++;
    tick();
    DrawX = 10'd320; DrawY = 10'd128; #1;
    n_total++; if (is_boss_missile !== 1'b1) $display("FAIL move_draw_centre got=%b exp=1", is_boss_missile); else n_pass++;
    DrawY = 10'd123; #1;
    n_total++; if (is_boss_missile !== 1'b0) $display("FAIL move_draw_old got=%b exp=0", is_boss_missile); else n_pass++;
    DrawY = 10'd132; #1;
    n_total++; if (is_boss_missile !== 1'b1) $display("FAIL move_draw_below got=%b exp=1", is_boss_missile); else n_pass++;
  endtask

  task automatic test_hit_invuln();
    int t_hit;
    t_hit = -1;
    player_x_pos = 10'd320; player_y_pos = 10'd400;
    for (int t = 0; t < 200; t++) begin
      tick();
      n_total++;
      if (is_player_hit !== m_hit) $display("FAIL hit_pulse t=%0d got=%b exp=%b", t, is_player_hit, m_hit);
      else n_pass++;
      if (m_hit) begin t_hit = t; break; end
    end
    n_total++; if (t_hit < 0) $display("FAIL hit_timeout got=none exp=hit"); else n_pass++;
    n_total++; if (lives !== 3'd2) $display("FAIL hit_lives got=%0d exp=2", lives); else n_pass++;
    n_total++; if (missile_active !== 3'b010) $display("FAIL hit_active got=%b exp=010", missile_active); else n_pass++;
    @(negedge Clk);
    n_total++; if (is_player_hit !== 1'b0) $display("FAIL hit_pulse_width got=%b exp=0", is_player_hit); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      player_y_pos = 10'(m_y[1] + 4);
      tick();
      n_total++;
      if (is_player_hit !== 1'b0 || lives !== 3'd2 || missile_active[1] !== 1'b1)
        $display("FAIL invuln k=%0d got hit=%b lives=%0d act=%b exp hit=0 lives=2 act1=1", k, is_player_hit, lives, missile_active);
      else n_pass++;
    end
  endtask

  task automatic test_dead();
    player_x_pos = 10'd320; player_y_pos = 10'd400;
    for (int t = 0; t < 600 && !m_dead; t++) begin
      tick();
      n_total++;
      if (missile_active !== m_act_vec() || lives !== 3'(m_lives) || is_player_hit !== m_hit || is_player_dead !== m_dead)
        $display("FAIL dead_run t=%0d got act=%b lives=%0d hit=%b dead=%b exp act=%b lives=%0d hit=%b dead=%b",
                 t, missile_active, lives, is_player_hit, is_player_dead, m_act_vec(), m_lives, m_hit, m_dead);
      else n_pass++;
    end
    n_total++; if (is_player_dead !== 1'b1) $display("FAIL dead_flag got=%b exp=1", is_player_dead); else n_pass++;
    n_total++; if (lives !== 3'd0) $display("FAIL dead_lives got=%0d exp=0", lives); else n_pass++;
    for (int t = 0; t < 200; t++) begin
      tick();
      n_total++;
      if (missile_active !== '0 || is_player_dead !== 1'b1 || lives !== 3'd0)
        $display("FAIL dead_hold t=%0d got act=%b dead=%b lives=%0d exp act=000 dead=1 lives=0", t, missile_active, is_player_dead, lives);
      else n_pass++;
    end
  endtask

  task automatic test_same_tick_free();
    player_x_pos = 10'd0; player_y_pos = 10'd0;
    do_reset();
    enable = 1'b1; boss_x_pos = 10'd320; boss_y_pos = 10'd1000;
    for (int t = 1; t <= 180; t++) begin
      tick();
      n_total++;
      if (missile_active !== m_act_vec()) $display("FAIL free_run t=%0d got=%b exp=%b", t, missile_active, m_act_vec());
      else n_pass++;
      if (t == 179) begin
        n_total++; if (missile_active !== 3'b011) $display("FAIL free_busy got=%b exp=011", missile_active); else n_pass++;
      end
    end
    n_total++; if (missile_active !== 3'b011) $display("FAIL free_reuse got=%b exp=011", missile_active); else n_pass++;
    DrawX = 10'd320; DrawY = 10'd0; #1;
    n_total++; if (is_boss_missile !== 1'b1) $display("FAIL free_new_draw got=%b exp=1", is_boss_missile); else n_pass++;
    DrawY = 10'd476; #1;
    n_total++; if (is_boss_missile !== 1'b0) $display("FAIL free_old_draw got=%b exp=0", is_boss_missile); else n_pass++;
    DrawY = 10'd240; #1;
    n_total++; if (is_boss_missile !== 1'b1) $display("FAIL free_slot1_draw got=%b exp=1", is_boss_missile); else n_pass++;
  endtask

`ifdef BOSS_MISSILE_AIM_EN
  task automatic test_aim();
    player_x_pos = 10'd0; player_y_pos = 10'd0;
    do_reset();
    enable = 1'b1; boss_x_pos = 10'd40; boss_y_pos = 10'd100;
    repeat (60) tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      DrawX = 10'(40 - 2 * k); DrawY = 10'(124 + 4 * k); #1;
      n_total++;
      if (is_boss_missile !== 1'b1 || missile_active[0] !== 1'b1)
        $display("FAIL aim_track k=%0d got draw=%b act=%b exp draw=1 act0=1", k, is_boss_missile, missile_active);
      else n_pass++;
    end
    tick();
    n_total++; if (missile_active[0] !== 1'b0) $display("FAIL aim_edge_clear got=%b exp=0", missile_active[0]); else n_pass++;
  endtask
`endif

  task automatic test_random();
    int s, v;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      n_total++;
      if (missile_active !== '0 || lives !== 3'd3)
        $display("FAIL rand_reset seg=%0d got act=%b lives=%0d exp act=000 lives=3", seg, missile_active, lives);
      else n_pass++;
      for (int t = 0; t < 250; t++) begin
        enable = ($urandom_range(0, 7) != 0);
        if (t % 20 == 0) begin
          boss_x_pos = 10'($urandom_range(100, 540));
          boss_y_pos = 10'($urandom_range(0, 200));
        end
        v = int'(boss_x_pos) + int'($urandom_range(0, 40)) - 20;
        player_x_pos = 10'((v < 0) ? 0 : v);
        player_y_pos = 10'($urandom_range(150, 470));
        tick();
        n_total++;
        if (missile_active !== m_act_vec() || lives !== 3'(m_lives) || is_player_hit !== m_hit || is_player_dead !== m_dead)
          $display("FAIL rand_state seg=%0d t=%0d got act=%b lives=%0d hit=%b dead=%b exp act=%b lives=%0d hit=%b dead=%b",
                   seg, t, missile_active, lives, is_player_hit, is_player_dead, m_act_vec(), m_lives, m_hit, m_dead);
        else n_pass++;
        s = int'($urandom_range(0, N - 1));
        if (m_act[s]) begin
          v = m_x[s] + int'($urandom_range(0, 6)) - 3; DrawX = 10'((v < 0) ? 0 : v);
          v = m_y[s] + int'($urandom_range(0, 10)) - 5; DrawY = 10'((v < 0) ? 0 : v);
        end else begin
          DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479));
        end
        #1;
        n_total++;
        if (is_boss_missile !== m_draw(int'(DrawX), int'(DrawY)))
          $display("FAIL rand_draw (%0d,%0d) got=%b exp=%b", DrawX, DrawY, is_boss_missile, m_draw(int'(DrawX), int'(DrawY)));
        else n_pass++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_spawn();
    test_hit_invuln();
    test_dead();
    test_same_tick_free();
`ifdef BOSS_MISSILE_AIM_EN
    test_aim();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
